// File: rtl/sandbox_pkg.sv
// Shared opcodes, status bit positions and state encodings for the sandbox processor.
package sandbox_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    OP_QUERY     = 2'b00,
    OP_START     = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_QUERY_ALL = 2'b11
  } opcode_e;

  localparam int unsigned ST_OK      = 0;
  localparam int unsigned ST_SUCCESS = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_BAD_CH  = 3;

  typedef enum logic [2:0] {
    HS_IDLE    = 3'd0,
    HS_TX      = 3'd1,
    HS_HOLD    = 3'd2,
    HS_ACK     = 3'd3,
    HS_RELEASE = 3'd4
  } hs_state_e;

  typedef enum logic [2:0] {
    IND_WAIT  = 3'd0,
    IND_ARMED = 3'd1,
    IND_HI0   = 3'd2,
    IND_ON    = 3'd3,
    IND_HI1   = 3'd4
  } ind_state_e;

endpackage

// File: rtl/sandbox_indicator.sv
// Reception LED: armed by a command, lit on the next slowClock fall, cleared on the one after.
module sandbox_indicator
  import sandbox_pkg::*;
(
  input  logic masterClock,
  input  logic reset,
  input  logic slowClock,
  input  logic trigger,
  output logic rxIndicator
);

  ind_state_e state_q, state_d;
  logic       rx_q, rx_d;

  // Falls are found by walking through a "seen high" state before each low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IND_WAIT:  if (trigger)    state_d = IND_ARMED;
      IND_ARMED: if (slowClock)  state_d = IND_HI0;
      IND_HI0:   if (!slowClock) state_d = IND_ON;
      IND_ON:    if (slowClock)  state_d = IND_HI1;
      IND_HI1:   if (!slowClock) state_d = IND_WAIT;
      default:                   state_d = IND_WAIT;
    endcase
    rx_d = (state_d == IND_ON) || (state_d == IND_HI1);
  end

  // Indicator state and registered LED output.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state_q <= IND_WAIT;
      rx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
    end
  end

  assign rxIndicator = rx_q;

endmodule

// File: rtl/sandbox_multi_process.sv
// Host-command processor dispatching START/QUERY/CLEAR/QUERY_ALL to NUM_CH trial engines.
module sandbox_multi_process
  import sandbox_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     masterClock,
  input  logic                     reset,
  input  logic                     slowClock,
  input  logic                     dataReceived,
  input  logic [7:0]               control,
  input  logic [31:0]              inputData,
  output logic                     clearDR,
  output logic                     transmitData,
  output logic [7:0]               status,
  output logic [31:0]              outputData,
  output logic                     rxIndicator,
  output logic [NUM_CH-1:0]        chDoRun,
  output logic [NUM_CH-1:0]        chClear,
  input  logic [NUM_CH-1:0]        chIsRunning,
  input  logic [NUM_CH-1:0]        chDidRun,
  input  logic [NUM_CH-1:0]        chSuccess,
  input  logic [NUM_CH*ADDR_W-1:0] chAddress
);

  hs_state_e   state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] data_q, data_d;
  logic        tx_q, tx_d;
  logic        clr_dr_q, clr_dr_d;
  logic [NUM_CH-1:0] do_run_q, do_run_d;
  logic [NUM_CH-1:0] ch_clear_q, ch_clear_d;
  logic        accept;

  // Channel inputs padded to MAX_CH so a 4-bit index is always in range.
  logic [MAX_CH-1:0]       run_pad, did_pad, succ_pad;
  logic [MAX_CH*CNT_W-1:0] addr_pad, cyc_pad;

  opcode_e     op;
  logic [3:0]  ch;
  logic        ch_ok;
  logic        sel_run, sel_did, sel_succ;
  logic [31:0] sel_addr, sel_cyc;

  logic [7:0]        resp_status;
  logic [31:0]       resp_data;
  logic [MAX_CH-1:0] run_onehot, clr_onehot;

  logic unused_inputs;
  assign unused_inputs = ^{inputData, control[5:4]};

  assign run_pad  = MAX_CH'(chIsRunning);
  assign did_pad  = MAX_CH'(chDidRun);
  assign succ_pad = MAX_CH'(chSuccess & chDidRun);

  assign op       = opcode_e'(control[7:6]);
  assign ch       = control[3:0];
  assign ch_ok    = (32'(ch) < NUM_CH);
  assign sel_run  = run_pad[ch];
  assign sel_did  = did_pad[ch];
  assign sel_succ = succ_pad[ch];
  assign sel_addr = addr_pad[{ch, 5'd0} +: CNT_W];
  assign sel_cyc  = cyc_pad[{ch, 5'd0} +: CNT_W];

  // Per-channel run-time counters; padding slots read as zero.
  for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
    if (c < NUM_CH) begin : g_live
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Clear wins over increment; increment saturates at all-ones.
      always_comb begin
        cnt_d = cnt_q;
        if (do_run_q[c] || ch_clear_q[c]) begin
          cnt_d = '0;
        end else if (chIsRunning[c] && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter register.
      always_ff @(posedge masterClock) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cyc_pad[c*CNT_W +: CNT_W]  = cnt_q;
      assign addr_pad[c*CNT_W +: CNT_W] = CNT_W'(chAddress[c*ADDR_W +: ADDR_W]);
    end else begin : g_pad
      assign cyc_pad[c*CNT_W +: CNT_W]  = '0;
      assign addr_pad[c*CNT_W +: CNT_W] = '0;
    end
  end

  // Response and pulse selection for the command currently on control.
  always_comb begin
    resp_status = {ch, 4'b0000};
    resp_data   = '0;
    run_onehot  = '0;
    clr_onehot  = '0;
    if (op == OP_QUERY_ALL) begin
      resp_status[ST_OK] = 1'b1;
      resp_data          = {succ_pad, did_pad};
    end else if (!ch_ok) begin
      resp_status[ST_BAD_CH] = 1'b1;
    end else begin
      case (op)
        OP_START: begin
          if (sel_run) begin
            resp_status[ST_BUSY] = 1'b1;
          end else if (sel_did) begin
            resp_status[ST_SUCCESS] = 1'b1;
          end else begin
            resp_status[ST_OK] = 1'b1;
            run_onehot[ch]     = 1'b1;
          end
        end
        OP_CLEAR: begin
          if (sel_run) begin
            resp_status[ST_BUSY] = 1'b1;
          end else begin
            resp_status[ST_OK] = 1'b1;
            clr_onehot[ch]     = 1'b1;
          end
        end
        OP_QUERY: begin
          resp_status[ST_OK]      = sel_did;
          resp_status[ST_SUCCESS] = sel_succ;
          resp_status[ST_BUSY]    = sel_run;
          if (sel_did) begin
            resp_data = sel_succ ? sel_cyc : sel_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake sequencing: capture at IDLE exit, then TX/HOLD/ACK/RELEASE.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    data_d     = data_q;
    tx_d       = tx_q;
    clr_dr_d   = clr_dr_q;
    do_run_d   = '0;
    ch_clear_d = '0;
    accept     = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (dataReceived) begin
          accept     = 1'b1;
          state_d    = HS_TX;
          status_d   = resp_status;
          data_d     = resp_data;
          do_run_d   = run_onehot[NUM_CH-1:0];
          ch_clear_d = clr_onehot[NUM_CH-1:0];
        end
      end
      HS_TX: begin
        tx_d    = 1'b1;
        state_d = HS_HOLD;
      end
      HS_HOLD: state_d = HS_ACK;
      HS_ACK: begin
        clr_dr_d = 1'b1;
        state_d  = HS_RELEASE;
      end
      HS_RELEASE: begin
        if (!dataReceived) begin
          tx_d     = 1'b0;
          clr_dr_d = 1'b0;
          state_d  = HS_IDLE;
        end
      end
      default: begin
        tx_d     = 1'b0;
        clr_dr_d = 1'b0;
        state_d  = HS_IDLE;
      end
    endcase
  end

  // Handshake state and registered outputs.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state_q    <= HS_IDLE;
      status_q   <= '0;
      data_q     <= '0;
      tx_q       <= 1'b0;
      clr_dr_q   <= 1'b0;
      do_run_q   <= '0;
      ch_clear_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      clr_dr_q   <= clr_dr_d;
      do_run_q   <= do_run_d;
      ch_clear_q <= ch_clear_d;
    end
  end

  sandbox_indicator u_indicator (
    .masterClock (masterClock),
    .reset       (reset),
    .slowClock   (slowClock),
    .trigger     (accept),
    .rxIndicator (rxIndicator)
  );

  assign status       = status_q;
  assign outputData   = data_q;
  assign transmitData = tx_q;
  assign clearDR      = clr_dr_q;
  assign chDoRun      = do_run_q;
  assign chClear      = ch_clear_q;

endmodule

// File: tb/tb_sandbox_multi_process.sv
// Self-checking bench for sandbox_multi_process (NUM_CH = 4, ADDR_W = 32).
module tb_sandbox_multi_process;

  logic         masterClock = 1'b0;
  logic         reset = 1'b1;
  logic         slowClock = 1'b0;
  logic         dataReceived = 1'b0;
  logic [7:0]   control = '0;
  logic [31:0]  inputData = '0;
  logic         clearDR, transmitData, rxIndicator;
  logic [7:0]   status;
  logic [31:0]  outputData;
  logic [3:0]   chDoRun, chClear;
  logic [3:0]   chIsRunning = '0;
  logic [3:0]   chDidRun = '0;
  logic [3:0]   chSuccess = '0;
  logic [127:0] chAddress;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [39:0] sb_q[$];
  logic        tx_prev = 1'b0;

  always #5 masterClock = ~masterClock;

  sandbox_multi_process #(.NUM_CH(4), .ADDR_W(32)) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .slowClock    (slowClock),
    .dataReceived (dataReceived),
    .control      (control),
    .inputData    (inputData),
    .clearDR      (clearDR),
    .transmitData (transmitData),
    .status       (status),
    .outputData   (outputData),
    .rxIndicator  (rxIndicator),
    .chDoRun      (chDoRun),
    .chClear      (chClear),
    .chIsRunning  (chIsRunning),
    .chDidRun     (chDidRun),
    .chSuccess    (chSuccess),
    .chAddress    (chAddress)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic [3:0]  run;
    logic [3:0]  did;
    logic [3:0]  succ;
    logic [7:0]  st;
    logic [31:0] dat;
    logic [3:0]  prun;
    logic [3:0]  pclr;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] st, input logic [31:0] dat);
    sb_q.push_back({st, dat});
    n_push++;
  endtask

  // Scoreboard: each rising transmitData must deliver the oldest expected response.
  always @(negedge masterClock) begin
    logic [39:0] e;
    if (transmitData && !tx_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got status %h data %h expected no response", status, outputData);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        chk("resp_status", {24'd0, status}, {24'd0, e[39:32]});
        chk("resp_data", outputData, e[31:0]);
      end
    end
    tx_prev = transmitData;
  end

  // Full command handshake with timing and pulse checks; address inputs are
  // scrambled after the capture edge to show they are not re-sampled.
  task automatic cmd(input logic [7:0] ctrl, input logic [7:0] est, input logic [31:0] edat,
                     input logic [3:0] erun, input logic [3:0] eclr);
    logic [127:0] saved;
    @(negedge masterClock);
    control      = ctrl;
    dataReceived = 1'b1;
    push_exp(est, edat);
    @(negedge masterClock);
    chk("pulse_run_k1", {28'd0, chDoRun}, {28'd0, erun});
    chk("pulse_clr_k1", {28'd0, chClear}, {28'd0, eclr});
    chk("tx_k", {31'd0, transmitData}, 32'd0);
    saved     = chAddress;
    chAddress = ~chAddress;
    @(negedge masterClock);
    chk("tx_k1", {31'd0, transmitData}, 32'd1);
    chk("pulse_run_k2", {28'd0, chDoRun}, 32'd0);
    chk("pulse_clr_k2", {28'd0, chClear}, 32'd0);
    @(negedge masterClock);
    chk("clrdr_k2", {31'd0, clearDR}, 32'd0);
    @(negedge masterClock);
    chk("clrdr_k3", {31'd0, clearDR}, 32'd1);
    dataReceived = 1'b0;
    chAddress    = saved;
    @(negedge masterClock);
    chk("release_tx", {31'd0, transmitData}, 32'd0);
    chk("release_clrdr", {31'd0, clearDR}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clrdr"}, {31'd0, clearDR}, 32'd0);
    chk({tag, "_tx"}, {31'd0, transmitData}, 32'd0);
    chk({tag, "_status"}, {24'd0, status}, 32'd0);
    chk({tag, "_data"}, outputData, 32'd0);
    chk({tag, "_rx"}, {31'd0, rxIndicator}, 32'd0);
    chk({tag, "_dorun"}, {28'd0, chDoRun}, 32'd0);
    chk({tag, "_chclr"}, {28'd0, chClear}, 32'd0);
  endtask

  initial begin
    chAddress = {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_1111};

    //            ctrl    run      did      succ     st     dat           prun     pclr
    tbl[0]  = '{8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0,         4'b0000, 4'b0000};
    tbl[1]  = '{8'h42, 4'b0000, 4'b0000, 4'b0000, 8'h21, 32'h0,         4'b0100, 4'b0000};
    tbl[2]  = '{8'h42, 4'b0100, 4'b0000, 4'b0000, 8'h24, 32'h0,         4'b0000, 4'b0000};
    tbl[3]  = '{8'h43, 4'b0000, 4'b1000, 4'b0000, 8'h32, 32'h0,         4'b0000, 4'b0000};
    tbl[4]  = '{8'h45, 4'b0000, 4'b0000, 4'b0000, 8'h58, 32'h0,         4'b0000, 4'b0000};
    tbl[5]  = '{8'h01, 4'b0000, 4'b0010, 4'b0000, 8'h11, 32'hDEAD_BEEF, 4'b0000, 4'b0000};
    tbl[6]  = '{8'h03, 4'b0000, 4'b1000, 4'b1000, 8'h33, 32'h0,         4'b0000, 4'b0000};
    tbl[7]  = '{8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h04, 32'h0,         4'b0000, 4'b0000};
    tbl[8]  = '{8'h81, 4'b0010, 4'b0000, 4'b0000, 8'h14, 32'h0,         4'b0000, 4'b0000};
    tbl[9]  = '{8'h83, 4'b0000, 4'b0000, 4'b0000, 8'h31, 32'h0,         4'b0000, 4'b1000};
    tbl[10] = '{8'h8F, 4'b0000, 4'b0000, 4'b0000, 8'hF8, 32'h0,         4'b0000, 4'b0000};
    tbl[11] = '{8'hC0, 4'b0000, 4'b0110, 4'b0010, 8'h01, 32'h0002_0006, 4'b0000, 4'b0000};
    tbl[12] = '{8'h09, 4'b0000, 4'b0000, 4'b0000, 8'h98, 32'h0,         4'b0000, 4'b0000};
    tbl[13] = '{8'hC7, 4'b0000, 4'b1111, 4'b1010, 8'h71, 32'h000A_000F, 4'b0000, 4'b0000};
    tbl[14] = '{8'h02, 4'b0000, 4'b0100, 4'b0000, 8'h21, 32'h1234_5678, 4'b0000, 4'b0000};

    // Reset state.
    repeat (3) @(negedge masterClock);
    chk_all_zero("reset");
    reset = 1'b0;

    // Table-driven commands.
    for (int unsigned i = 0; i < 15; i++) begin
      chIsRunning = tbl[i].run;
      chDidRun    = tbl[i].did;
      chSuccess   = tbl[i].succ;
      cmd(tbl[i].ctrl, tbl[i].st, tbl[i].dat, tbl[i].prun, tbl[i].pclr);
    end
    chIsRunning = '0;
    chDidRun    = '0;
    chSuccess   = '0;

    // Ch2 runs 37 cycles and passes; ch1 fails.
    cmd(8'h42, 8'h21, 32'h0, 4'b0100, 4'b0000);
    @(negedge masterClock);
    chIsRunning = 4'b0100;
    repeat (37) @(negedge masterClock);
    chIsRunning = 4'b0000;
    chDidRun    = 4'b0110;
    chSuccess   = 4'b0100;
    cmd(8'h02, 8'h23, 32'd37, 4'b0000, 4'b0000);
    cmd(8'h01, 8'h11, 32'hDEAD_BEEF, 4'b0000, 4'b0000);
    // Clear ch2, confirm its counter is zero, then restart.
    cmd(8'h82, 8'h21, 32'h0, 4'b0000, 4'b0100);
    cmd(8'h02, 8'h23, 32'h0, 4'b0000, 4'b0000);
    chDidRun  = 4'b0000;
    chSuccess = 4'b0000;
    cmd(8'h42, 8'h21, 32'h0, 4'b0100, 4'b0000);

    // Let ch0 accumulate a non-zero count before the reset sequence.
    chIsRunning = 4'b0001;
    repeat (6) @(negedge masterClock);
    chIsRunning = 4'b0000;

    // Reset in RELEASE with dataReceived held high.
    @(negedge masterClock);
    control      = 8'h41;
    dataReceived = 1'b1;
    push_exp(8'h11, 32'h0);
    repeat (5) @(negedge masterClock);
    chk("rel_tx", {31'd0, transmitData}, 32'd1);
    chk("rel_clrdr", {31'd0, clearDR}, 32'd1);
    reset     = 1'b1;
    control   = 8'h00;
    chDidRun  = 4'b0001;
    chSuccess = 4'b0001;
    push_exp(8'h03, 32'h0);
    @(negedge masterClock);
    chk_all_zero("midreset");
    reset = 1'b0;
    @(negedge masterClock);
    chk("post_reset_status", {24'd0, status}, 32'h03);
    chk("post_reset_data", outputData, 32'h0);
    chk("post_reset_tx", {31'd0, transmitData}, 32'd0);
    @(negedge masterClock);
    chk("post_reset_tx1", {31'd0, transmitData}, 32'd1);
    repeat (2) @(negedge masterClock);
    chk("post_reset_clrdr", {31'd0, clearDR}, 32'd1);
    dataReceived = 1'b0;
    @(negedge masterClock);
    chk("post_reset_idle", {31'd0, transmitData}, 32'd0);
    chDidRun  = 4'b0000;
    chSuccess = 4'b0000;

    // Saturation: preload ch0 near the top, run past the wrap point.
    @(negedge masterClock);
    force dut.g_ch[0].g_live.cnt_q = 32'hFFFF_FFFC;
    #1;
    release dut.g_ch[0].g_live.cnt_q;
    chIsRunning = 4'b0001;
    repeat (8) @(negedge masterClock);
    chIsRunning = 4'b0000;
    chDidRun    = 4'b0001;
    chSuccess   = 4'b0001;
    cmd(8'h00, 8'h03, 32'hFFFF_FFFF, 4'b0000, 4'b0000);
    chDidRun  = 4'b0000;
    chSuccess = 4'b0000;

    // Indicator: already armed by earlier commands, slowClock has stayed low.
    slowClock = 1'b1;
    repeat (3) @(negedge masterClock);
    chk("ind_armed", {31'd0, rxIndicator}, 32'd0);
    slowClock = 1'b0;
    repeat (2) @(negedge masterClock);
    chk("ind_on", {31'd0, rxIndicator}, 32'd1);
    slowClock = 1'b1;
    repeat (2) @(negedge masterClock);
    chk("ind_on_hi", {31'd0, rxIndicator}, 32'd1);
    slowClock = 1'b0;
    repeat (2) @(negedge masterClock);
    chk("ind_off", {31'd0, rxIndicator}, 32'd0);
    slowClock = 1'b1;
    repeat (2) @(negedge masterClock);
    slowClock = 1'b0;
    repeat (2) @(negedge masterClock);
    chk("ind_no_rearm", {31'd0, rxIndicator}, 32'd0);
    cmd(8'h00, 8'h00, 32'h0, 4'b0000, 4'b0000);
    slowClock = 1'b1;
    repeat (2) @(negedge masterClock);
    slowClock = 1'b0;
    repeat (2) @(negedge masterClock);
    chk("ind_rearm", {31'd0, rxIndicator}, 32'd1);

    repeat (2) @(negedge masterClock);
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("sb_pops", n_pop, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
